// File: rtl/outport_alloc.sv
// Output-port allocator: round-robin wormhole lock per packet with credit-gated flit transfer.
// Optional stall watchdog enabled by defining ALLOC_WDOG_EN.
module outport_alloc #(
  parameter int unsigned NR        = 5,
  parameter int unsigned WIDTH     = $clog2(NR),
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned CW        = $clog2(BUF_DEPTH + 1),
  parameter int unsigned WDOG_CYC  = 64
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [NR-1:0] REQ,
  input  logic [NR-1:0] TAIL,
  input  logic          CREDIT_IN,
  output logic [NR-1:0] GRT,
  output logic          FIRE,
  output logic          LOCK,
  output logic [CW-1:0] CREDIT_CNT,
  output logic          WDOG_ERR
);

  typedef enum logic {S_IDLE, S_LOCKED} state_e;

  state_e           state_q, state_d;
  logic [NR-1:0]    grt_q, grt_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic [WIDTH-1:0] ptr_q, ptr_d;
  logic             lock_q, lock_d;
  logic [CW-1:0]    cred_q, cred_d;
  logic             wdog_err_q, wdog_err_d;
  logic             fire_c, tail_g, win_vld;
  logic [WIDTH-1:0] win_idx;

  if (NR < 2 || WDOG_CYC < 1) begin : g_bad_cfg
    $error("outport_alloc: NR must be >= 2 and WDOG_CYC >= 1");
  end

  // Index base+off wrapped into 0..NR-1 (base is always < NR)
  function automatic logic [WIDTH-1:0] rr_idx(input logic [WIDTH-1:0] base,
                                              input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NR) s = s - NR;
    return WIDTH'(s);
  endfunction

  assign fire_c = (|(grt_q & REQ)) && (cred_q != '0);
  assign tail_g = |(grt_q & TAIL);

  // Scan from ptr downward in reverse so the last hit is the first requester at or above ptr
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      if (REQ[rr_idx(ptr_q, NR - 1 - k)]) begin
        win_vld = 1'b1;
        win_idx = rr_idx(ptr_q, NR - 1 - k);
      end
    end
  end

  always_comb begin
    cred_d = cred_q;
    if (fire_c && !CREDIT_IN) begin
      cred_d = cred_q - CW'(1);
    end else if (CREDIT_IN && !fire_c && (cred_q != CW'(BUF_DEPTH))) begin
      cred_d = cred_q + CW'(1);
    end
  end

`ifdef ALLOC_WDOG_EN
  localparam int unsigned WDW = $clog2(WDOG_CYC + 1);
  logic [WDW-1:0] wdog_cnt_q, wdog_cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    grt_d      = grt_q;
    g_d        = g_q;
    ptr_d      = ptr_q;
    wdog_err_d = 1'b0;
`ifdef ALLOC_WDOG_EN
    wdog_cnt_d = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_LOCKED;
          g_d     = win_idx;
          grt_d   = {{(NR-1){1'b0}}, 1'b1} << win_idx;
        end
      end
      S_LOCKED: begin
        if (fire_c && tail_g) begin
          state_d = S_IDLE;
          grt_d   = '0;
          ptr_d   = rr_idx(g_q, 1);
        end
`ifdef ALLOC_WDOG_EN
        else if (!fire_c) begin
          // Release a lock that has stalled for WDOG_CYC consecutive cycles
          if (wdog_cnt_q == WDW'(WDOG_CYC - 1)) begin
            state_d    = S_IDLE;
            grt_d      = '0;
            ptr_d      = rr_idx(g_q, 1);
            wdog_err_d = 1'b1;
          end else begin
            wdog_cnt_d = wdog_cnt_q + WDW'(1);
          end
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
        grt_d   = '0;
      end
    endcase
    lock_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      grt_q      <= '0;
      g_q        <= '0;
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      cred_q     <= CW'(BUF_DEPTH);
      wdog_err_q <= 1'b0;
`ifdef ALLOC_WDOG_EN
      wdog_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grt_q      <= grt_d;
      g_q        <= g_d;
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      cred_q     <= cred_d;
      wdog_err_q <= wdog_err_d;
`ifdef ALLOC_WDOG_EN
      wdog_cnt_q <= wdog_cnt_d;
`endif
    end
  end

  assign GRT        = grt_q;
  assign FIRE       = fire_c;
  assign LOCK       = lock_q;
  assign CREDIT_CNT = cred_q;
  assign WDOG_ERR   = wdog_err_q;

endmodule
